// File: rtl/dcfifo_arb_pkg.sv
// Shared types and helpers for the dual-clock FIFO write-side scheduler.
// rr_pick is sized for the largest supported requester count and trimmed by callers.
package dcfifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  localparam int unsigned MaxReq = 8;
  localparam int unsigned MaxIdW = 3;

  typedef struct packed {
    logic              found;
    logic [MaxIdW-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of valid_vec searching rr_ptr+1, rr_ptr+2, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid_vec,
                                       input logic [MaxIdW-1:0] rr_ptr,
                                       input int unsigned       n);
    rr_pick_t    res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      pos = (32'(rr_ptr) + k) % n;
      if (!res.found && (k <= n) && valid_vec[pos[MaxIdW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[MaxIdW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: rotate past rr_ptr, priority-encode, unrotate.
// Shared by the write and read side schedulers.
module rr_arb_pick
  import dcfifo_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = id_width(N)
) (
  input  logic [N-1:0]   valid_vec,
  input  logic [IdW-1:0] rr_ptr,
  output logic           found,
  output logic [IdW-1:0] idx
);

  logic [MaxReq-1:0] valid_ext;
  logic [MaxIdW-1:0] ptr_ext;
  rr_pick_t          res;

  assign valid_ext = MaxReq'(valid_vec);
  assign ptr_ext   = MaxIdW'(rr_ptr);
  assign res       = rr_pick(valid_ext, ptr_ext, N);
  assign found     = res.found;
  assign idx       = res.idx[IdW-1:0];

endmodule

// File: rtl/dcfifo_wr_arbiter.sv
// Shares one dual-clock FIFO write port among N_REQ requesters, round-robin,
// holding each grant until end of packet or MAX_BURST beats.
module dcfifo_wr_arbiter
  import dcfifo_arb_pkg::*;
#(
  parameter int unsigned  N_REQ     = 4,
  parameter int unsigned  WIDTH     = 16,
  parameter int unsigned  MAX_BURST = 8,
  localparam int unsigned ID_W      = id_width(N_REQ)
) (
  input  logic                   aclr,
  input  logic                   wrclk,
  input  logic                   enable,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   fifo_wrreq,
  output logic [WIDTH+ID_W:0]    fifo_data,
  input  logic                   fifo_wrfull,
  output logic                   grant_valid,
  output logic [ID_W-1:0]        grant_id,
  output logic                   burst_cut
);

  arb_state_e      state_q, state_d;
  logic            grant_valid_q, grant_valid_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic            burst_cut_q, burst_cut_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             sel_valid, sel_last, accept, release_beat;
  logic [WIDTH-1:0] sel_data;

  rr_arb_pick #(
    .N   (N_REQ),
    .IdW (ID_W)
  ) u_pick (
    .valid_vec (req_valid),
    .rr_ptr    (rr_ptr_q),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // Ready depends only on grant state and wrfull, never on req_valid.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = grant_valid_q & ~fifo_wrfull;
      end
    end
  end

  assign accept       = grant_valid_q & sel_valid & ~fifo_wrfull;
  assign release_beat = accept & (sel_last | (beat_cnt_q == 8'(MAX_BURST - 1)));
  assign fifo_wrreq   = accept;
  assign fifo_data    = {grant_id_q, sel_last, sel_data};
  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign burst_cut    = burst_cut_q;

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    burst_cut_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && pick_found) begin
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
          beat_cnt_d    = '0;
          state_d       = StGrant;
        end
      end
      StGrant: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if (release_beat) begin
          beat_cnt_d    = '0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = grant_id_q;
          burst_cut_d   = ~sel_last;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      state_q       <= StIdle;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= ID_W'(N_REQ - 1);
      beat_cnt_q    <= '0;
      burst_cut_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      burst_cut_q   <= burst_cut_d;
    end
  end

endmodule

// File: tb/tb_dcfifo_wr_arbiter.sv
// Bench for dcfifo_wr_arbiter: per-requester beat queues drive the DUT, a rule-level
// grant model and per-source scoreboard are compared every cycle, plus directed literals.
module tb_dcfifo_wr_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int MB  = 8;
  localparam int IDW = 2;

  logic           aclr, wrclk, enable, fifo_wrfull;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           fifo_wrreq, grant_valid, burst_cut;
  logic [W+IDW:0] fifo_data;
  logic [IDW-1:0] grant_id;

  int total = 0;
  int bad   = 0;

  logic [W:0] drv_q [N][$];
  logic [W:0] sb_q  [N][$];

  int         log_id  [$];
  logic [W-1:0] log_dat [$];
  logic       log_last[$];
  int         log_cyc [$];

  int cyc = 0, cut_cnt = 0, quiet_cnt = 0;
  bit exp_gv, exp_cut;
  int exp_gid, m_ptr, m_beats;

  dcfifo_wr_arbiter #(
    .N_REQ     (N),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .aclr        (aclr),
    .wrclk       (wrclk),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_wrreq  (fifo_wrreq),
    .fifo_data   (fifo_data),
    .fifo_wrfull (fifo_wrfull),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .burst_cut   (burst_cut)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_pkt(input int r, input int n, input int base);
    logic [W:0] e;
    for (int k = 0; k < n; k++) begin
      e = {(k == n - 1), W'(base + k)};
      drv_q[r].push_back(e);
      sb_q[r].push_back(e);
    end
  endtask

  // Model: grant rules stated directly (pick after last owner, hold to last/MB beats).
  task automatic check_cycle();
    logic [N-1:0] er;
    bit ewr, lst;
    int id;
    if (aclr) begin
      chk("rst_grant_valid", grant_valid, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_fifo_wrreq", fifo_wrreq, 0);
      chk("rst_burst_cut", burst_cut, 0);
      exp_gv = 0; exp_gid = 0; exp_cut = 0; m_ptr = N - 1; m_beats = 0;
      return;
    end
    er  = (exp_gv && !fifo_wrfull) ? (N'(1) << exp_gid) : '0;
    ewr = exp_gv && req_valid[exp_gid] && !fifo_wrfull;
    chk("grant_valid", grant_valid, exp_gv);
    chk("grant_id", grant_id, exp_gid);
    chk("burst_cut", burst_cut, exp_cut);
    chk("req_ready", req_ready, er);
    chk("fifo_wrreq", fifo_wrreq, ewr);
    if (burst_cut === 1'b1) cut_cnt++;
    if (fifo_wrfull && exp_gv && req_ready == '0 && fifo_wrreq === 1'b0) quiet_cnt++;
    if (fifo_wrreq === 1'b1) begin
      id = int'(fifo_data[W+IDW:W+1]);
      chk("sb_nonempty", sb_q[id].size() > 0, 1);
      if (sb_q[id].size() > 0) begin
        chk("sb_beat", fifo_data[W:0], sb_q[id][0]);
        void'(sb_q[id].pop_front());
      end
      log_id.push_back(id);
      log_dat.push_back(fifo_data[W-1:0]);
      log_last.push_back(fifo_data[W]);
      log_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i] === 1'b1) void'(drv_q[i].pop_front());
    exp_cut = 0;
    if (exp_gv) begin
      if (ewr) begin
        lst = req_last[exp_gid];
        m_beats++;
        if (lst || m_beats == MB) begin
          exp_gv = 0; m_ptr = exp_gid; exp_cut = !lst; m_beats = 0;
        end
      end
    end else if (enable && req_valid != '0) begin
      for (int k = 1; k <= N; k++)
        if (!exp_gv && req_valid[(m_ptr + k) % N]) begin
          exp_gv = 1; exp_gid = (m_ptr + k) % N;
        end
    end
  endtask

  always @(negedge wrclk) begin
    logic [N-1:0]   v, l;
    logic [N*W-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++)
      if (drv_q[i].size() > 0) begin
        v[i] = 1'b1;
        l[i] = drv_q[i][0][W];
        d[i*W +: W] = drv_q[i][0][W-1:0];
      end
    req_valid = v; req_last = l; req_data = d;
    #1;
    cyc++;
    check_cycle();
  end

  task automatic wait_drain(input string nm);
    int t = 0;
    bit busy;
    do begin
      @(posedge wrclk); #2;
      t++;
      busy = grant_valid;
      for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) busy = 1;
    end while (busy && t < 2000);
    chk(nm, t < 2000, 1);
  endtask

  task automatic wait_log(input int n, input string nm);
    int t = 0;
    while (log_id.size() < n && t < 2000) begin
      @(posedge wrclk);
      t++;
    end
    chk(nm, t < 2000, 1);
  endtask

  task automatic do_reset();
    @(posedge wrclk); #2 aclr = 1'b1;
    @(posedge wrclk); #2 aclr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int b, pc, cb, qb, e;
    aclr = 1'b1; enable = 1'b1; fifo_wrfull = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    repeat (2) @(posedge wrclk);
    #2 aclr = 1'b0;
    #1;
    chk("lit_rst_gv", grant_valid, 0);
    chk("lit_rst_wrreq", fifo_wrreq, 0);
    chk("lit_rst_ready", req_ready, 0);

    // Single 3-beat packet from requester 0.
    b = log_id.size();
    @(posedge wrclk); #1;
    pc = cyc;
    push_pkt(0, 3, 'hA1);
    wait_drain("t1_drain");
    chk("t1_count", log_id.size() - b, 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_id", log_id[b+k], 0);
      chk("t1_data", log_dat[b+k], 'hA1 + k);
      chk("t1_last", log_last[b+k], (k == 2));
    end
    chk("t1_latency", log_cyc[b] - pc, 2);
    chk("t1_back2back", log_cyc[b+2] - log_cyc[b], 2);

    // All requesters, 2-beat packets, from reset.
    do_reset();
    b = log_id.size();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_pkt(i, 2, 'h100 * i + 2 * r);
    wait_drain("t3_drain");
    chk("t3_count", log_id.size() - b, 24);
    for (int k = 0; k < 24; k++) chk("t3_id", log_id[b+k], (k / 2) % 4);
    chk("t3_span", log_cyc[b+23] - log_cyc[b], 34);

    // 20-beat packet from 2 cut into 8+8+4, requester 1 slots in after the first cut.
    b = log_id.size(); cb = cut_cnt;
    push_pkt(2, 20, 'h200);
    repeat (3) @(posedge wrclk);
    #1 push_pkt(1, 3, 'h10);
    wait_drain("t4_drain");
    chk("t4_count", log_id.size() - b, 23);
    for (int k = 0; k < 23; k++) begin
      e = (k >= 8 && k < 11) ? 1 : 2;
      chk("t4_id", log_id[b+k], e);
    end
    chk("t4_cuts", cut_cnt - cb, 2);
    chk("t4_last_r1", log_last[b+10], 1);
    chk("t4_resume", log_dat[b+11], 'h208);
    chk("t4_final", log_dat[b+22], 'h213);

    // wrfull for 5 cycles mid-packet; burst cut must still land after 8 beats.
    b = log_id.size(); cb = cut_cnt; qb = quiet_cnt;
    push_pkt(3, 10, 'h300);
    wait_log(b + 2, "t5_wait");
    #1 fifo_wrfull = 1'b1;
    repeat (5) @(posedge wrclk);
    #1 fifo_wrfull = 1'b0;
    wait_drain("t5_drain");
    chk("t5_quiet", quiet_cnt - qb, 5);
    chk("t5_count", log_id.size() - b, 10);
    chk("t5_stall", log_cyc[b+2] - log_cyc[b+1], 6);
    chk("t5_cuts", cut_cnt - cb, 1);
    chk("t5_cut_gap", log_cyc[b+8] - log_cyc[b+7], 2);

    // aclr during beat 2 of a 4-beat packet.
    b = log_id.size();
    push_pkt(2, 4, 'h400);
    wait_log(b + 2, "t6_wait");
    #2 aclr = 1'b1;
    #1;
    chk("t6_async_gv", grant_valid, 0);
    chk("t6_async_wrreq", fifo_wrreq, 0);
    chk("t6_async_ready", req_ready, 0);
    push_pkt(0, 2, 'h500);
    @(posedge wrclk); #2 aclr = 1'b0;
    wait_drain("t6_drain");
    chk("t6_count", log_id.size() - b, 6);
    chk("t6_first_id", log_id[b+2], 0);
    chk("t6_resume_id", log_id[b+4], 2);
    chk("t6_resume_data", log_dat[b+4], 'h402);

    // enable dropped mid-grant: grant completes, then no new grant until re-enabled.
    b = log_id.size();
    push_pkt(3, 4, 'h700);
    wait_log(b + 1, "t7_wait");
    #1 enable = 1'b0;
    push_pkt(1, 2, 'h600);
    wait_log(b + 4, "t7_wait2");
    repeat (4) @(posedge wrclk);
    #1;
    chk("t7_hold_gv", grant_valid, 0);
    chk("t7_hold_count", log_id.size() - b, 4);
    enable = 1'b1;
    wait_drain("t7_drain");
    chk("t7_count", log_id.size() - b, 6);
    chk("t7_id", log_id[b+4], 1);

    for (int i = 0; i < N; i++) chk("sb_leftover", sb_q[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
